snake_tile_map: RTL and testbench

//  Upstream stage of the VGA sprite renderer: owns the 40x30 tile map of the snake playfield.

---
 rtl/snake_tile_pkg.sv | 38 +++
 rtl/snake_tile_ram.sv | 28 ++
 rtl/snake_tile_map.sv | 148 ++++++++++++++
 tb/tb_snake_tile_map.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_tile_pkg.sv
// Shared constants, register map, tile codes and index helper for the snake tile map.
package snake_tile_pkg;

  localparam int COLS      = 40;
  localparam int ROWS      = 30;
  localparam int TYPE_W    = 4;
  localparam int ADDR_W    = 11;
  localparam int MAP_DEPTH = 2048;

  localparam logic [2:0] REG_X    = 3'd0;
  localparam logic [2:0] REG_Y    = 3'd1;
  localparam logic [2:0] REG_TYPE = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  // Tail-right has no code of its own; the renderer derives it from direction logic.
  typedef enum logic [3:0] {
    EMPTY   = 4'd0,  APPLE   = 4'd1,  HEAD_R  = 4'd2,  HEAD_L  = 4'd3,
    HEAD_U  = 4'd4,  HEAD_D  = 4'd5,  BODY_H  = 4'd6,  BODY_V  = 4'd7,
    BODY_TL = 4'd8,  BODY_TR = 4'd9,  BODY_BL = 4'd10, BODY_BR = 4'd11,
    TAIL_U  = 4'd12, TAIL_D  = 4'd13, TAIL_L  = 4'd14, WALL    = 4'd15
  } tile_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } map_state_t;

  // Row-major index y*40 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] tile_index(input logic [7:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] xe;
    logic [ADDR_W-1:0] ye;
    xe = {3'b000, x};
    ye = {3'b000, y};
    return (ye << 5) + (ye << 3) + xe;
  endfunction

endpackage

// File: rtl/snake_tile_ram.sv
// Simple dual-port tile RAM with registered read; coded for block-RAM inference.
module snake_tile_ram
  import snake_tile_pkg::*;
#(
  parameter int DATA_W = TYPE_W,
  parameter int ADDR_W = snake_tile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [1<<ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/snake_tile_map.sv
// Playfield tile map: Avalon-MM host staging/commit, clear engine and renderer read port.
module snake_tile_map
  import snake_tile_pkg::*;
#(
  parameter int COLS           = snake_tile_pkg::COLS,
  parameter int ROWS           = snake_tile_pkg::ROWS,
  parameter int TYPE_W         = snake_tile_pkg::TYPE_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  input  logic [5:0]        rd_tile_x,
  input  logic [4:0]        rd_tile_y,
  output logic [TYPE_W-1:0] rd_tile_type,
  output logic              busy
);

  localparam logic [7:0]        COLS_B   = 8'(COLS);
  localparam logic [7:0]        ROWS_B   = 8'(ROWS);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

  map_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [TYPE_W-1:0] fill_q, fill_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [7:0]        readdata_q, readdata_d;
  logic              oor_q, oor_d, dropped_q, dropped_d;
  logic              rd_zero_q, rd_zero_d;
  logic              wr_en, rd_en, in_range;
  logic [7:0]        rx, ry;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [TYPE_W-1:0] ram_wdata, ram_rdata;

  assign busy     = (state_q == ST_CLEAR);
  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign in_range = (x_q < COLS_B) && (y_q < ROWS_B);
  assign rx       = {2'b00, rd_tile_x};
  assign ry       = {3'b000, rd_tile_y};

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    x_d        = x_q;
    y_d        = y_q;
    oor_d      = oor_q;
    dropped_d  = dropped_q;
    readdata_d = '0;
    ram_we     = 1'b0;
    ram_waddr  = tile_index(x_q, y_q);
    ram_wdata  = writedata[TYPE_W-1:0];
    ram_raddr  = tile_index(rx, ry);
    rd_zero_d  = !((rx < COLS_B) && (ry < ROWS_B));

    // A STAT read clears the flags; a flag raised in the same cycle still wins below.
    if (rd_en) begin
      case (address)
        REG_X:    readdata_d = x_q;
        REG_Y:    readdata_d = y_q;
        REG_STAT: begin
          readdata_d = {5'b00000, oor_q, dropped_q, busy};
          oor_d      = 1'b0;
          dropped_d  = 1'b0;
        end
        default:  readdata_d = '0;
      endcase
    end

    if (wr_en) begin
      case (address)
        REG_X: x_d = writedata;
        REG_Y: y_d = writedata;
        REG_TYPE: begin
          if (busy)           dropped_d = 1'b1;
          else if (!in_range) oor_d     = 1'b1;
          else                ram_we    = 1'b1;
        end
        REG_CTRL: begin
          if (busy) begin
            dropped_d = 1'b1;
          end else if (writedata[0]) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
            fill_d     = writedata[4 +: TYPE_W];
          end
        end
        default: ;
      endcase
    end

    if (state_q == ST_CLEAR) begin
      ram_we     = 1'b1;
      ram_waddr  = clr_addr_q;
      ram_wdata  = fill_q;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == CLR_LAST) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_IDLE;
      clr_addr_q <= '0;
      fill_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      oor_q      <= 1'b0;
      dropped_q  <= 1'b0;
      readdata_q <= '0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
      x_q        <= x_d;
      y_q        <= y_d;
      oor_q      <= oor_d;
      dropped_q  <= dropped_d;
      readdata_q <= readdata_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  snake_tile_ram #(
    .DATA_W (TYPE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign readdata     = readdata_q;
  assign rd_tile_type = rd_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_snake_tile_map.sv
// Randomized bench for snake_tile_map against an array model of the 40x30 map and sticky flags.
module tb_snake_tile_map;
  import snake_tile_pkg::*;

  logic       clk = 1'b0;
  logic       reset1, reset0, cs1, cs0, write, read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [5:0] rd_tile_x;
  logic [4:0] rd_tile_y;
  logic [7:0] readdata1, readdata0;
  logic [3:0] rd_type1, rd_type0;
  logic       busy1, busy0;

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int model_map [30][40];
  bit m_oor, m_dropped;

  snake_tile_map #(.CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .chipselect(cs1), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata1),
    .rd_tile_x(rd_tile_x), .rd_tile_y(rd_tile_y), .rd_tile_type(rd_type1), .busy(busy1)
  );

  snake_tile_map #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .chipselect(cs0), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata0),
    .rd_tile_x(rd_tile_x), .rd_tile_y(rd_tile_y), .rd_tile_type(rd_type0), .busy(busy0)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_tile(input int x, input int y);
    if (x < 40 && y < 30) return model_map[y][x];
    return 0;
  endfunction

  task automatic fill_model(input int v);
    for (int yy = 0; yy < 30; yy++)
      for (int xx = 0; xx < 40; xx++) model_map[yy][xx] = v;
  endtask

  task automatic av_write(input bit sel, input logic [2:0] a, input logic [7:0] d);
    cs1 = !sel; cs0 = sel; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    cs1 = 1'b0; cs0 = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input bit sel, input logic [2:0] a, output logic [7:0] d);
    cs1 = !sel; cs0 = sel; read = 1'b1; address = a;
    @(negedge clk);
    cs1 = 1'b0; cs0 = 1'b0; read = 1'b0;
    d = sel ? readdata0 : readdata1;
  endtask

  task automatic commit(input int x, input int y, input int t, input bit in_clear);
    av_write(1'b0, REG_X, x[7:0]);
    av_write(1'b0, REG_Y, y[7:0]);
    av_write(1'b0, REG_TYPE, t[7:0]);
    if (in_clear)                 m_dropped = 1'b1;
    else if (x >= 40 || y >= 30)  m_oor = 1'b1;
    else                          model_map[y][x] = t;
  endtask

  task automatic stat_check(input string tag, input bit busy_exp);
    logic [7:0] d;
    av_read(1'b0, REG_STAT, d);
    check_eq(tag, d, {m_oor, m_dropped, busy_exp});
    m_oor = 1'b0;
    m_dropped = 1'b0;
  endtask

  task automatic rd_tile(input int x, input int y, input string tag);
    rd_tile_x = x[5:0];
    rd_tile_y = y[4:0];
    @(negedge clk);
    check_eq(tag, rd_type1, exp_tile(x, y));
  endtask

  task automatic sweep(input string tag);
    int px = 0;
    int py = 0;
    for (int i = 0; i <= 1200; i++) begin
      if (i > 0) check_eq($sformatf("%s(%0d,%0d)", tag, px, py), rd_type1, exp_tile(px, py));
      if (i < 1200) begin
        px = i % 40;
        py = i / 40;
        rd_tile_x = px[5:0];
        rd_tile_y = py[4:0];
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_end(input bit sel, input int unsigned t0, input string tag);
    int guard = 0;
    while ((sel ? busy0 : busy1) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, int'(cyc - t0), 1200);
  endtask

  initial begin
    int unsigned t0;
    logic [7:0]  d;
    int          px, py, guard;

    reset1 = 1'b1; reset0 = 1'b1; cs1 = 1'b0; cs0 = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; rd_tile_x = '0; rd_tile_y = '0;
    m_oor = 1'b0; m_dropped = 1'b0;
    fill_model(0);
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", readdata1, 0);
    check_eq("rst_rd_type", rd_type1, 0);

    // Power-up clear, then garbage, then a second reset-triggered clear
    reset1 = 1'b0; t0 = cyc;
    check_eq("busy_after_rst", busy1, 1);
    wait_busy_end(1'b0, t0, "clear_len_first");
    for (int i = 0; i < 40; i++)
      commit($urandom_range(39, 0), $urandom_range(29, 0), $urandom_range(15, 1), 1'b0);
    av_write(1'b0, REG_X, 8'd33);
    reset1 = 1'b1;
    repeat (2) @(negedge clk);
    reset1 = 1'b0; t0 = cyc;
    fill_model(0);
    check_eq("busy_after_rst2", busy1, 1);
    av_read(1'b0, REG_X, d);
    check_eq("x_after_rst", d, 0);
    stat_check("stat_in_rst_clear", 1'b1);
    wait_busy_end(1'b0, t0, "clear_len_rst");
    sweep("zero_map");

    // Single commit and its neighbours
    commit(5, 3, 1, 1'b0);
    rd_tile(5, 3, "tile_5_3");
    rd_tile(4, 3, "tile_4_3");
    rd_tile(5, 4, "tile_5_4");

    // Out-of-range commit is discarded and raises oor
    commit(40, 0, 2, 1'b0);
    rd_tile(0, 1, "no_wrap_0_1");
    rd_tile(40, 0, "rd_oor_40_0");
    stat_check("stat_oor", 1'b0);
    stat_check("stat_oor_cleared", 1'b0);

    // Random commits (some out of range) and random renderer reads
    for (int i = 0; i < 60; i++)
      commit($urandom_range(47, 0), $urandom_range(33, 0), $urandom_range(15, 0), 1'b0);
    stat_check("stat_rand", 1'b0);
    px = 0; py = 0;
    for (int i = 0; i <= 200; i++) begin
      if (i > 0) check_eq($sformatf("rand_rd(%0d,%0d)", px, py), rd_type1, exp_tile(px, py));
      px = $urandom_range(63, 0);
      py = $urandom_range(31, 0);
      rd_tile_x = px[5:0];
      rd_tile_y = py[4:0];
      @(negedge clk);
    end

    // Host clear with fill 15; commits and CTRL writes during it are dropped
    av_write(1'b0, REG_CTRL, 8'hF1); t0 = cyc;
    check_eq("busy_ctrl", busy1, 1);
    repeat (96) @(negedge clk);
    commit(2, 2, 5, 1'b1);
    av_write(1'b0, REG_CTRL, 8'h01);
    m_dropped = 1'b1;
    stat_check("stat_dropped", 1'b1);
    wait_busy_end(1'b0, t0, "clear_len_ctrl");
    fill_model(15);
    sweep("fill15");
    stat_check("stat_after_fill", 1'b0);

    // Corner commits
    commit(39, 29, 7, 1'b0);
    commit(0, 0, 3, 1'b0);
    rd_tile(39, 29, "corner_39_29");
    rd_tile(0, 0, "corner_0_0");
    rd_tile(38, 29, "near_38_29");
    rd_tile(39, 28, "near_39_28");
    rd_tile(1, 0, "near_1_0");
    rd_tile(0, 1, "near_0_1");

    // Instance without clear-on-reset: reset aborts a clear mid-way
    reset0 = 1'b0;
    check_eq("nc_busy_rel", busy0, 0);
    @(negedge clk);
    check_eq("nc_busy_next", busy0, 0);
    av_write(1'b1, REG_CTRL, 8'hF1); t0 = cyc;
    check_eq("nc_busy_ctrl", busy0, 1);
    av_write(1'b1, REG_X, 8'd9);
    av_write(1'b1, REG_TYPE, 8'd4);
    guard = 0;
    while (cyc - t0 < 598 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("nc_busy_mid", busy0, 1);
    av_read(1'b1, REG_X, d);
    check_eq("nc_x_before", d, 9);
    reset0 = 1'b1;
    @(negedge clk);
    check_eq("nc_rst_readdata", readdata0, 0);
    check_eq("nc_rst_rd_type", rd_type0, 0);
    @(negedge clk);
    reset0 = 1'b0;
    check_eq("nc_busy_abort", busy0, 0);
    @(negedge clk);
    check_eq("nc_busy_abort_next", busy0, 0);
    check_eq("nc_readdata_idle", readdata0, 0);
    av_read(1'b1, REG_STAT, d);
    check_eq("nc_stat_flags", d, 0);
    av_read(1'b1, REG_X, d);
    check_eq("nc_x_reset", d, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
